// File: rtl/spi_aes_slave_if.sv
// Bundle of SPI pins and AES-core handshake signals for spi_aes_slave.
// slave modport is the view of spi_aes_slave; master modport is the view of
// whatever drives the SPI link and hosts the AES core.
interface spi_aes_slave_if;
  // SPI link
  logic         sclk;
  logic         cs_n;
  logic         mosi;
  logic         miso;
  // AES core handshake
  logic         core_start;
  logic         core_enc;
  logic [1:0]   core_nk;
  logic [255:0] core_key;
  logic [127:0] core_data;
  logic         core_done;
  logic [127:0] core_result;
  // Status pulses
  logic         done_out_Enc;
  logic         done_out_Dec;
  logic         frame_err;

  modport slave (
    input  sclk, cs_n, mosi, core_done, core_result,
    output miso, core_start, core_enc, core_nk, core_key, core_data,
           done_out_Enc, done_out_Dec, frame_err
  );

  modport master (
    output sclk, cs_n, mosi, core_done, core_result,
    input  miso, core_start, core_enc, core_nk, core_key, core_data,
           done_out_Enc, done_out_Dec, frame_err
  );
endinterface

// File: rtl/spi_aes_slave.sv
// SPI mode-0 slave in front of an AES encrypt/decrypt core.
// A write frame carries a command byte, a 256-bit key and a 128-bit block;
// once complete the core is launched and its result latched. A read frame
// returns the latched result MSB first. SPI lines are oversampled on clk.
// Optional build macro SPI_AES_SLAVE_STATUS_EN: while the command byte is
// being received, miso returns {result_ready, busy, 6'b0}; otherwise miso
// stays 0 outside the read-back phase.
module spi_aes_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  spi_aes_slave_if.slave  bus
);

`ifdef SPI_AES_SLAVE_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RX_KEY,
    RX_DATA,
    LAUNCH,
    BUSY,
    TX
  } state_t;

  state_t state;

  // Synchronisers and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_q;
  logic                   cs_q;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sclk_rise_ev;
  logic                   sclk_fall_ev;

  // Frame bookkeeping
  logic [8:0]   bit_cnt;
  logic [6:0]   cmd_sr;
  logic [7:0]   cmd_word;
  logic [6:0]   stat_sr;
  logic         bframe;
  logic [255:0] key_sr;
  logic [127:0] data_sr;
  logic [126:0] tx_sr;
  logic [127:0] result;
  logic         result_ready;

  // Registered outputs
  logic         miso_q;
  logic         core_start_q;
  logic         core_enc_q;
  logic [1:0]   core_nk_q;
  logic [255:0] core_key_q;
  logic [127:0] core_data_q;
  logic         done_enc_q;
  logic         done_dec_q;
  logic         frame_err_q;

  // Bring the asynchronous SPI lines into the clk domain, keeping one extra
  // stage of sclk/cs_n for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      cs_q      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign cs_fall = cs_q & ~cs_s;
  assign cs_rise = ~cs_q & cs_s;

  // sclk edges only count while chip select is low; a cs_n rise in the same
  // cycle therefore always wins over a coincident sclk edge.
  assign sclk_rise_ev = sclk_s & ~sclk_q & ~cs_s;
  assign sclk_fall_ev = ~sclk_s & sclk_q & ~cs_s;

  // Command byte as it will look after the current rise is shifted in.
  assign cmd_word = {cmd_sr, mosi_s};

  // Key and block shift registers; their contents only reach the core after
  // a complete frame, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == RX_KEY && sclk_rise_ev) begin
      key_sr <= {key_sr[254:0], mosi_s};
    end
    if (state == RX_DATA && sclk_rise_ev) begin
      data_sr <= {data_sr[126:0], mosi_s};
    end
  end

  // Frame FSM: command decode, launch, busy wait, read-back and abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      cmd_sr       <= '0;
      stat_sr      <= '0;
      bframe       <= 1'b0;
      tx_sr        <= '0;
      result       <= '0;
      result_ready <= 1'b0;
      miso_q       <= 1'b0;
      core_start_q <= 1'b0;
      core_enc_q   <= 1'b0;
      core_nk_q    <= '0;
      core_key_q   <= '0;
      core_data_q  <= '0;
      done_enc_q   <= 1'b0;
      done_dec_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      done_enc_q   <= 1'b0;
      done_dec_q   <= 1'b0;
      frame_err_q  <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= CMD;
            bit_cnt <= '0;
            miso_q  <= STATUS_EN & result_ready;
            stat_sr <= 7'b0;
          end
        end

        CMD: begin
          if (cs_rise) begin
            frame_err_q <= 1'b1;
            miso_q      <= 1'b0;
            state       <= IDLE;
          end else if (sclk_fall_ev) begin
            miso_q  <= STATUS_EN & stat_sr[6];
            stat_sr <= {stat_sr[5:0], 1'b0};
          end else if (sclk_rise_ev) begin
            cmd_sr  <= cmd_word[6:0];
            bit_cnt <= bit_cnt + 9'd1;
            if (bit_cnt == 9'd7) begin
              bit_cnt <= '0;
              miso_q  <= 1'b0;
              if (cmd_word[7]) begin
                if (result_ready) begin
                  state  <= TX;
                  tx_sr  <= result[126:0];
                  miso_q <= result[127];
                end else begin
                  frame_err_q <= 1'b1;
                  state       <= IDLE;
                end
              end else if (cmd_word[5:4] == 2'b11) begin
                frame_err_q <= 1'b1;
                state       <= IDLE;
              end else begin
                state <= RX_KEY;
              end
            end
          end
        end

        RX_KEY: begin
          if (cs_rise) begin
            frame_err_q <= 1'b1;
            state       <= IDLE;
          end else if (sclk_rise_ev) begin
            if (bit_cnt == 9'd255) begin
              bit_cnt <= '0;
              state   <= RX_DATA;
            end else begin
              bit_cnt <= bit_cnt + 9'd1;
            end
          end
        end

        RX_DATA: begin
          if (cs_rise) begin
            frame_err_q <= 1'b1;
            state       <= IDLE;
          end else if (sclk_rise_ev) begin
            if (bit_cnt == 9'd127) begin
              bit_cnt <= '0;
              state   <= LAUNCH;
            end else begin
              bit_cnt <= bit_cnt + 9'd1;
            end
          end
        end

        LAUNCH: begin
          core_key_q   <= key_sr;
          core_data_q  <= data_sr;
          core_enc_q   <= cmd_sr[6];
          core_nk_q    <= cmd_sr[5:4];
          core_start_q <= 1'b1;
          result_ready <= 1'b0;
          bframe       <= 1'b0;
          state        <= BUSY;
        end

        BUSY: begin
          if (bus.core_done) begin
            result       <= bus.core_result;
            result_ready <= 1'b1;
            done_enc_q   <= core_enc_q;
            done_dec_q   <= ~core_enc_q;
            bframe       <= 1'b0;
            miso_q       <= 1'b0;
            state        <= IDLE;
          end else if (bframe) begin
            // A frame opened while busy: take in its command byte, then reject it.
            if (cs_rise) begin
              frame_err_q <= 1'b1;
              bframe      <= 1'b0;
              miso_q      <= 1'b0;
            end else if (sclk_fall_ev) begin
              miso_q  <= STATUS_EN & stat_sr[6];
              stat_sr <= {stat_sr[5:0], 1'b0};
            end else if (sclk_rise_ev) begin
              bit_cnt <= bit_cnt + 9'd1;
              if (bit_cnt == 9'd7) begin
                frame_err_q <= 1'b1;
                bframe      <= 1'b0;
                miso_q      <= 1'b0;
              end
            end
          end else if (cs_fall) begin
            bframe  <= 1'b1;
            bit_cnt <= '0;
            miso_q  <= STATUS_EN & result_ready;
            stat_sr <= 7'b1000000;
          end
        end

        TX: begin
          // bit_cnt counts master sample rises; the fall that follows the
          // command byte keeps result[127] on the line for the first sample.
          if (cs_rise) begin
            frame_err_q <= (bit_cnt != 9'd128);
            miso_q      <= 1'b0;
            state       <= IDLE;
          end else if (sclk_rise_ev) begin
            if (bit_cnt != 9'd128) begin
              bit_cnt <= bit_cnt + 9'd1;
            end
          end else if (sclk_fall_ev) begin
            if (bit_cnt == 9'd128) begin
              miso_q <= 1'b0;
              state  <= IDLE;
            end else if (bit_cnt != 9'd0) begin
              miso_q <= tx_sr[126];
              tx_sr  <= {tx_sr[125:0], 1'b0};
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.miso         = miso_q;
  assign bus.core_start   = core_start_q;
  assign bus.core_enc     = core_enc_q;
  assign bus.core_nk      = core_nk_q;
  assign bus.core_key     = core_key_q;
  assign bus.core_data    = core_data_q;
  assign bus.done_out_Enc = done_enc_q;
  assign bus.done_out_Dec = done_dec_q;
  assign bus.frame_err    = frame_err_q;

endmodule

// File: tb/tb_spi_aes_slave.sv
// Bench for spi_aes_slave: bit-banged SPI master, stub AES core and a
// frame-level model of what the slave must report.
module tb_spi_aes_slave;

  localparam int H = 5;  // sclk half period in clk cycles
  localparam logic [255:0] KAT_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
`ifdef SPI_AES_SLAVE_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_aes_slave_if bus();

  spi_aes_slave dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Pulse counters and launch snapshot
  int           n_start = 0;
  int           n_enc   = 0;
  int           n_dec   = 0;
  int           n_err   = 0;
  logic [255:0] snap_key  = '0;
  logic [127:0] snap_data = '0;
  logic [1:0]   snap_nk   = '0;
  logic         snap_enc  = 1'b0;

  // Stub AES core plus a manual done injector
  bit           stub_on     = 1'b1;
  int           stub_delay  = 10;
  int           stub_cnt    = 0;
  logic         stub_done   = 1'b0;
  logic [127:0] stub_result = '0;
  logic         inj_done    = 1'b0;
  logic [127:0] inj_result  = '0;

  assign bus.core_done   = stub_done | inj_done;
  assign bus.core_result = inj_done ? inj_result : stub_result;

  // Frame-level reference model
  bit           model_ready   = 1'b0;
  bit           model_busy    = 1'b0;
  logic [127:0] model_result  = '0;
  logic [127:0] model_pending = '0;

  function automatic logic [127:0] stub_fn(input logic [255:0] k, input logic [127:0] d,
                                           input logic e, input logic [1:0] nk);
    if (k == KAT_KEY && e && d == KAT_PT) return KAT_CT;
    if (k == KAT_KEY && !e && d == KAT_CT) return KAT_PT;
    return d ^ k[255:128] ^ k[127:0] ^ {nk, 125'b0, e};
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] k = '0;
    for (int w = 0; w < 8; w++) k = {k[223:0], $urandom()};
    return k;
  endfunction

  function automatic logic [127:0] rand_blk();
    logic [127:0] b = '0;
    for (int w = 0; w < 4; w++) b = {b[95:0], $urandom()};
    return b;
  endfunction

  // Count output pulses and snapshot the core request on each start
  always @(negedge clk) begin
    if (bus.core_start) begin
      n_start   <= n_start + 1;
      snap_key  <= bus.core_key;
      snap_data <= bus.core_data;
      snap_nk   <= bus.core_nk;
      snap_enc  <= bus.core_enc;
    end
    if (bus.done_out_Enc) n_enc <= n_enc + 1;
    if (bus.done_out_Dec) n_dec <= n_dec + 1;
    if (bus.frame_err)    n_err <= n_err + 1;
  end

  // Stub core: answers a start after stub_delay cycles
  always @(negedge clk) begin
    stub_done <= 1'b0;
    if (bus.core_start && stub_on) begin
      stub_cnt <= stub_delay;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        stub_done   <= 1'b1;
        stub_result <= stub_fn(bus.core_key, bus.core_data, bus.core_enc, bus.core_nk);
      end
    end
  end

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bit-banged mode-0 transfer; miso is sampled just before each rise
  task automatic spi_xfer(input int nbits, input logic [391:0] tx, output logic [391:0] rx);
    rx = '0;
    bus.cs_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = tx[391-i];
      repeat (H) @(negedge clk);
      rx[391-i] = bus.miso;
      bus.sclk = 1'b1;
      repeat (H) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (H) @(negedge clk);
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    repeat (2*H) @(negedge clk);
  endtask

  task automatic wait_result(input string tag, input logic enc, input int e0, input int d0);
    for (int i = 0; i < 3000; i++) begin
      if (n_enc + n_dec != e0 + d0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check_val({tag, "_done_enc"}, 256'(n_enc - e0), 256'(enc));
    check_val({tag, "_done_dec"}, 256'(n_dec - d0), 256'(!enc));
    model_result = model_pending;
    model_ready  = 1'b1;
    model_busy   = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [7:0] cmd, input logic [255:0] key,
                          input logic [127:0] data, input bit wait_res);
    int s0, r0, e0, d0;
    logic [391:0] rx;
    s0 = n_start; r0 = n_err; e0 = n_enc; d0 = n_dec;
    spi_xfer(392, {cmd, key, data}, rx);
    check_val({tag, "_start"}, 256'(n_start - s0), 256'(1));
    check_val({tag, "_key"}, snap_key, key);
    check_val({tag, "_data"}, 256'(snap_data), 256'(data));
    check_val({tag, "_nk_enc"}, 256'({snap_nk, snap_enc}), 256'({cmd[5:4], cmd[6]}));
    model_pending = stub_fn(key, data, cmd[6], cmd[5:4]);
    model_ready   = 1'b0;
    model_busy    = 1'b1;
    if (wait_res) begin
      wait_result(tag, cmd[6], e0, d0);
      check_val({tag, "_err"}, 256'(n_err - r0), 256'(0));
    end
  endtask

  task automatic do_read(input string tag, output logic [127:0] got);
    int r0;
    logic [391:0] rx;
    logic [7:0]   exp_stat;
    r0 = n_err;
    exp_stat = {STAT & model_ready, STAT & model_busy, 6'b0};
    spi_xfer(136, {8'h80, 384'b0}, rx);
    got = rx[383:256];
    check_val({tag, "_stat"}, 256'(rx[391:384]), 256'(exp_stat));
    if (model_ready) begin
      check_val({tag, "_result"}, 256'(got), 256'(model_result));
      check_val({tag, "_err"}, 256'(n_err - r0), 256'(0));
    end else begin
      check_val({tag, "_miso0"}, 256'(got), 256'(0));
      check_val({tag, "_err"}, 256'(n_err - r0), 256'(1));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_miso"}, 256'(bus.miso), 256'(0));
    check_val({tag, "_ctl"}, 256'({bus.core_start, bus.core_enc, bus.core_nk}), 256'(0));
    check_val({tag, "_key"}, bus.core_key, 256'(0));
    check_val({tag, "_data"}, 256'(bus.core_data), 256'(0));
    check_val({tag, "_pulses"}, 256'({bus.done_out_Enc, bus.done_out_Dec, bus.frame_err}), 256'(0));
  endtask

  initial begin
    logic [127:0] got;
    logic [391:0] rx;
    logic [255:0] k;
    logic [127:0] d;
    logic [7:0]   cmd;
    int s0, r0, e0, d0;

    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");

    // Read before any result exists
    do_read("rd_empty", got);
    check_val("rd_empty_start", 256'(n_start), 256'(0));

    // Known-answer encrypt and decrypt round trips
    do_write("kat_enc", 8'h60, KAT_KEY, KAT_PT, 1'b1);
    do_read("kat_enc_rd", got);
    check_val("kat_enc_ct", 256'(got), 256'(KAT_CT));
    do_write("kat_dec", 8'h20, KAT_KEY, KAT_CT, 1'b1);
    do_read("kat_dec_rd", got);
    check_val("kat_dec_pt", 256'(got), 256'(KAT_PT));

    // Abort after 100 key bits; core outputs must keep the last request
    s0 = n_start; r0 = n_err;
    spi_xfer(108, {8'h60, rand_key(), rand_blk()}, rx);
    check_val("abort_err", 256'(n_err - r0), 256'(1));
    check_val("abort_start", 256'(n_start - s0), 256'(0));
    check_val("abort_key_kept", bus.core_key, KAT_KEY);
    do_write("post_abort", 8'h50, rand_key(), rand_blk(), 1'b1);
    do_read("post_abort_rd", got);

    // NK = 11 is rejected and leaves the stored result intact
    s0 = n_start; r0 = n_err;
    spi_xfer(392, {8'h70, rand_key(), rand_blk()}, rx);
    check_val("nk11_err", 256'(n_err - r0), 256'(1));
    check_val("nk11_start", 256'(n_start - s0), 256'(0));
    do_read("nk11_rd", got);

    // Frames opened while the core is busy
    stub_delay = 600;
    e0 = n_enc; d0 = n_dec;
    cmd = 8'h40;
    do_write("busy_wr", cmd, rand_key(), rand_blk(), 1'b0);
    r0 = n_err;
    spi_xfer(16, {8'h80, 384'b0}, rx);
    check_val("busy_rd_err", 256'(n_err - r0), 256'(1));
    check_val("busy_rd_stat", 256'(rx[391:376]), 256'({1'b0, STAT, 14'b0}));
    r0 = n_err;
    spi_xfer(16, {8'h20, 384'b0}, rx);
    check_val("busy_wr_err", 256'(n_err - r0), 256'(1));
    wait_result("busy", cmd[6], e0, d0);
    do_read("busy_after_rd", got);
    do_read("busy_reread", got);
    stub_delay = 10;

    // Randomised write/read transactions
    for (int t = 0; t < 3; t++) begin
      k = rand_key();
      d = rand_blk();
      cmd = {1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 4'($urandom())};
      do_write($sformatf("rnd%0d", t), cmd, k, d, 1'b1);
      do_read($sformatf("rnd%0d_rd", t), got);
    end

    // Reset while busy, then a late core_done
    stub_on = 1'b0;
    e0 = n_enc; d0 = n_dec;
    do_write("rst_busy", 8'h60, rand_key(), rand_blk(), 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("rst_busy_out");
    model_ready = 1'b0;
    model_busy  = 1'b0;
    inj_result = rand_blk();
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (5) @(negedge clk);
    check_val("late_done_pulses", 256'((n_enc - e0) + (n_dec - d0)), 256'(0));
    do_read("rst_busy_rd", got);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
